piece_queue: RTL



---
 rtl/piece_queue_if.sv | 24 ++
 rtl/piece_queue.sv | 107 ++++++++++
 2 files changed

// File: rtl/piece_queue_if.sv
// Handshake bundle between the game FSM (master) and the piece queue (slave).
interface piece_queue_if #(
   parameter int DEPTH = 4
);
   localparam int CW = $clog2(DEPTH + 1);

   logic [2:0]    randnum;
   logic          pop;
   logic [2:0]    head_piece;
   logic [2:0]    preview_piece;
   logic          head_valid;
   logic [CW-1:0] count;
   logic          pop_err;

   modport master (
      output randnum, pop,
      input  head_piece, preview_piece, head_valid, count, pop_err
   );

   modport slave (
      input  randnum, pop,
      output head_piece, preview_piece, head_valid, count, pop_err
   );
endinterface

// File: rtl/piece_queue.sv
// Buffered queue of piece codes (1..7) fed by the LFSR, with optional
// repeat filtering and a pop handshake for the spawn logic.
module piece_queue #(
   parameter int DEPTH      = 4,
   parameter int NO_REPEAT  = 1,
   parameter int MAX_REJECT = 2
) (
   input logic        Clk,
   input logic        Reset,
   piece_queue_if.slave q
);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int RW = $clog2(MAX_REJECT + 2);

   typedef enum logic [1:0] {EMPTY, FILLING, FULL} state_t;

   state_t        state;
   logic [2:0]    entries [DEPTH];
   logic [2:0]    ent_n   [DEPTH];
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_n;
   logic [CW-1:0] wr_pos;
   logic [2:0]    rand_q;
   logic [2:0]    last_acc;
   logic [RW-1:0] rej_cnt;
   logic          head_valid;
   logic          pop_err;
   logic          new_sample;
   logic          is_repeat;
   logic          pop_ok;
   logic          space;
   logic          push;

   always_comb begin
      new_sample = (q.randnum != rand_q) && (q.randnum != 3'd0);
      is_repeat  = (NO_REPEAT == 1) && (q.randnum == last_acc) &&
                   (rej_cnt < RW'(MAX_REJECT));
      pop_ok     = q.pop && (state != EMPTY);
      space      = (state != FULL) || pop_ok;
      push       = new_sample && space && !is_repeat;
      wr_pos     = pop_ok ? cnt - CW'(1) : cnt;

      // Shift first, then the push lands at the (possibly decremented) tail.
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (pop_ok)
            ent_n[i] = (i == DEPTH - 1) ? 3'd0 : entries[i + 1];
         else
            ent_n[i] = entries[i];
         if (push && (CW'(i) == wr_pos))
            ent_n[i] = q.randnum;
      end

      cnt_n = cnt;
      if (push && !pop_ok)
         cnt_n = cnt + CW'(1);
      else if (pop_ok && !push)
         cnt_n = cnt - CW'(1);
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state      <= EMPTY;
         cnt        <= '0;
         rand_q     <= '0;
         last_acc   <= '0;
         rej_cnt    <= '0;
         head_valid <= 1'b0;
         pop_err    <= 1'b0;
         for (int unsigned i = 0; i < DEPTH; i++)
            entries[i] <= '0;
      end else begin
         rand_q     <= q.randnum;
         pop_err    <= q.pop && (state == EMPTY);
         cnt        <= cnt_n;
         head_valid <= (cnt_n != '0);
         for (int unsigned i = 0; i < DEPTH; i++)
            entries[i] <= ent_n[i];

         if (new_sample && space) begin
            if (is_repeat) begin
               rej_cnt <= rej_cnt + RW'(1);
            end else begin
               last_acc <= q.randnum;
               rej_cnt  <= '0;
            end
         end

         case (state)
            EMPTY:   if (push) state <= FILLING;
            FILLING: begin
               if (cnt_n == CW'(DEPTH))
                  state <= FULL;
               else if (cnt_n == '0)
                  state <= EMPTY;
            end
            FULL:    if (pop_ok && !push) state <= FILLING;
            default: state <= EMPTY;
         endcase
      end
   end

   assign q.head_piece    = entries[0];
   assign q.preview_piece = entries[1];
   assign q.head_valid    = head_valid;
   assign q.count         = cnt;
   assign q.pop_err       = pop_err;
endmodule
